// File: rtl/sync_width_conv_fifo.sv
// Single-clock FIFO with asymmetric write and read widths.
// Storage is kept in narrow units (N = the smaller port width) and split into
// one bank per lane of the wider port. A wide access therefore touches one row
// of every bank in a single cycle, and a narrow access touches one bank.
// Pointers count narrow units. All flags and water levels are registered from
// the post-update occupancy, so no flag depends combinationally on wr_en/rd_en.

module sync_width_conv_fifo #(
    parameter int WR_DATA_WIDTH = 32,
    parameter int RD_DATA_WIDTH = 8,
    parameter int DEPTH_WIDTH   = 12,
    parameter bit MSB_FIRST     = 1'b1,
    parameter bit OUTPUT_REG    = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WR_DATA_WIDTH-1:0] wr_data,
    input  logic                     wr_en,
    output logic                     wr_full,
    output logic                     almost_full,
    output logic [DEPTH_WIDTH:0]     wr_water_level,
    input  logic [DEPTH_WIDTH:0]     af_thresh,
    output logic                     wr_overflow,
    output logic [RD_DATA_WIDTH-1:0] rd_data,
    input  logic                     rd_en,
    output logic                     rd_valid,
    output logic                     rd_empty,
    output logic                     almost_empty,
    output logic [DEPTH_WIDTH:0]     rd_water_level,
    input  logic [DEPTH_WIDTH:0]     ae_thresh,
    output logic                     rd_underflow
);

    localparam int N         = (WR_DATA_WIDTH < RD_DATA_WIDTH) ? WR_DATA_WIDTH : RD_DATA_WIDTH;
    localparam int WR_UNITS  = WR_DATA_WIDTH / N;
    localparam int RD_UNITS  = RD_DATA_WIDTH / N;
    localparam int MAX_UNITS = (WR_UNITS > RD_UNITS) ? WR_UNITS : RD_UNITS;
    localparam int LOGM      = $clog2(MAX_UNITS);
    localparam int LOG_WR    = $clog2(WR_UNITS);
    localparam int LOG_RD    = $clog2(RD_UNITS);
    localparam int ROW_W     = DEPTH_WIDTH - LOGM;
    localparam int ROWS      = 1 << ROW_W;

    localparam logic [DEPTH_WIDTH:0] WR_STEP  = (DEPTH_WIDTH + 1)'(WR_UNITS);
    localparam logic [DEPTH_WIDTH:0] RD_STEP  = (DEPTH_WIDTH + 1)'(RD_UNITS);
    localparam logic [DEPTH_WIDTH:0] CAPACITY = {1'b1, {DEPTH_WIDTH{1'b0}}};

    // Width ratio must be a power of two up to 16, and the depth must hold at
    // least two rows of the widest access.
    generate
        if ((WR_DATA_WIDTH % N) != 0 || (RD_DATA_WIDTH % N) != 0 ||
            MAX_UNITS > 16 || (1 << LOGM) != MAX_UNITS || DEPTH_WIDTH <= LOGM) begin : g_bad_ratio
            $error("sync_width_conv_fifo: illegal width ratio or depth");
        end
    endgenerate

    logic                   wr_accept;
    logic                   rd_accept;
    logic [DEPTH_WIDTH:0]   wr_ptr;
    logic [DEPTH_WIDTH:0]   rd_ptr;
    logic [DEPTH_WIDTH:0]   count;
    logic [DEPTH_WIDTH:0]   count_next;
    logic [DEPTH_WIDTH:0]   free_next;
    logic [DEPTH_WIDTH:0]   wr_level_next;
    logic [DEPTH_WIDTH:0]   rd_level_next;
    logic [ROW_W-1:0]       wr_row;
    logic [ROW_W-1:0]       rd_row;
    logic [N-1:0]           bank_q [MAX_UNITS];
    logic                   s1_valid;
    logic [RD_DATA_WIDTH-1:0] rd_word;
    logic                   out_valid_src;
    logic [RD_DATA_WIDTH-1:0] out_data_src;

    assign wr_accept = wr_en & ~wr_full;
    assign rd_accept = rd_en & ~rd_empty;
    assign wr_row    = wr_ptr[DEPTH_WIDTH-1:LOGM];
    assign rd_row    = rd_ptr[DEPTH_WIDTH-1:LOGM];

    // Occupancy after this edge's accepted write/read, used for every flag.
    always_comb begin
        count      = wr_ptr - rd_ptr;
        count_next = count;
        if (wr_accept) begin
            count_next = count_next + WR_STEP;
        end
        if (rd_accept) begin
            count_next = count_next - RD_STEP;
        end
        free_next     = CAPACITY - count_next;
        wr_level_next = count_next >> LOG_WR;
        rd_level_next = count_next >> LOG_RD;
    end

    // Pointers, status flags, water levels and error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            wr_full        <= 1'b0;
            rd_empty       <= 1'b1;
            almost_full    <= 1'b0;
            almost_empty   <= 1'b1;
            wr_water_level <= '0;
            rd_water_level <= '0;
            wr_overflow    <= 1'b0;
            rd_underflow   <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + WR_STEP;
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + RD_STEP;
            end
            wr_full        <= (free_next < WR_STEP);
            rd_empty       <= (count_next < RD_STEP);
            almost_full    <= (wr_level_next >= af_thresh);
            almost_empty   <= (rd_level_next <= ae_thresh);
            wr_water_level <= wr_level_next;
            rd_water_level <= rd_level_next;
            wr_overflow    <= wr_en & wr_full;
            rd_underflow   <= rd_en & rd_empty;
        end
    end

    generate
        for (genvar b = 0; b < MAX_UNITS; b++) begin : g_bank
            logic [N-1:0] mem [ROWS];
            logic [N-1:0] wdata;
            logic         we;
            logic [N-1:0] q;

            if (WR_UNITS == MAX_UNITS) begin : g_wide_wr
                localparam int LANE = MSB_FIRST ? (WR_UNITS - 1 - b) : b;
                assign wdata = wr_data[LANE*N +: N];
                assign we    = wr_accept;
            end else begin : g_narrow_wr
                assign wdata = wr_data;
                assign we    = wr_accept &&
                               ((wr_ptr[DEPTH_WIDTH-1:0] & DEPTH_WIDTH'(MAX_UNITS - 1)) == DEPTH_WIDTH'(b));
            end

            // Lane RAM: one write port, one registered read port, no reset.
            always_ff @(posedge clk) begin
                if (we) begin
                    mem[wr_row] <= wdata;
                end
                if (rd_accept) begin
                    q <= mem[rd_row];
                end
            end

            assign bank_q[b] = q;
        end
    endgenerate

    // Marks that the bank outputs hold a freshly read row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= rd_accept;
        end
    end

    generate
        if (RD_UNITS == MAX_UNITS) begin : g_wide_rd
            // Concatenate every bank into one read word in lane order.
            always_comb begin
                rd_word = '0;
                for (int i = 0; i < RD_UNITS; i++) begin
                    rd_word[((MSB_FIRST ? (RD_UNITS - 1 - i) : i) * N) +: N] = bank_q[i];
                end
            end
        end else begin : g_narrow_rd
            logic [DEPTH_WIDTH-1:0] s1_bank;

            // Remember which bank the narrow read addressed.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_bank <= '0;
                end else if (rd_accept) begin
                    s1_bank <= rd_ptr[DEPTH_WIDTH-1:0] & DEPTH_WIDTH'(MAX_UNITS - 1);
                end
            end

            // Select the addressed bank for the narrow read word.
            always_comb begin
                rd_word = '0;
                for (int b = 0; b < MAX_UNITS; b++) begin
                    if (s1_bank == DEPTH_WIDTH'(b)) begin
                        rd_word = bank_q[b];
                    end
                end
            end
        end
    endgenerate

    generate
        if (OUTPUT_REG) begin : g_pipe
            logic                     pipe_valid;
            logic [RD_DATA_WIDTH-1:0] pipe_data;

            // Extra pipeline stage between the RAM and the output register.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pipe_valid <= 1'b0;
                    pipe_data  <= '0;
                end else begin
                    pipe_valid <= s1_valid;
                    if (s1_valid) begin
                        pipe_data <= rd_word;
                    end
                end
            end

            assign out_valid_src = pipe_valid;
            assign out_data_src  = pipe_data;
        end else begin : g_no_pipe
            assign out_valid_src = s1_valid;
            assign out_data_src  = rd_word;
        end
    endgenerate

    // Output register: data holds between reads, valid pulses once per read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= out_valid_src;
            if (out_valid_src) begin
                rd_data <= out_data_src;
            end
        end
    end

endmodule

// File: tb/tb_sync_width_conv_fifo.sv
// Testbench for sync_width_conv_fifo: three instances (32->8 MSB first,
// 32->8 LSB first on a small depth, 8->32 with the extra output stage).
// Written words push their expected read words into per-instance queues;
// monitors pop and compare whenever rd_valid is seen.

module tb_sync_width_conv_fifo;

    logic clk;
    logic tb_rst;

    // Main instance: 32 -> 8, MSB first, depth 4096 units
    logic [31:0] m_wr_data;
    logic        m_wr_en, m_wr_full, m_almost_full, m_wr_overflow;
    logic [12:0] m_wr_water_level, m_af_thresh;
    logic [7:0]  m_rd_data;
    logic        m_rd_en, m_rd_valid, m_rd_empty, m_almost_empty, m_rd_underflow;
    logic [12:0] m_rd_water_level, m_ae_thresh;

    // LSB-first instance: 32 -> 8, depth 16 units
    logic [31:0] l_wr_data;
    logic        l_wr_en, l_wr_full, l_almost_full, l_wr_overflow;
    logic [4:0]  l_wr_water_level, l_af_thresh;
    logic [7:0]  l_rd_data;
    logic        l_rd_en, l_rd_valid, l_rd_empty, l_almost_empty, l_rd_underflow;
    logic [4:0]  l_rd_water_level, l_ae_thresh;

    // Upsize instance: 8 -> 32, MSB first, output register, depth 64 units
    logic [7:0]  u_wr_data;
    logic        u_wr_en, u_wr_full, u_almost_full, u_wr_overflow;
    logic [6:0]  u_wr_water_level, u_af_thresh;
    logic [31:0] u_rd_data;
    logic        u_rd_en, u_rd_valid, u_rd_empty, u_almost_empty, u_rd_underflow;
    logic [6:0]  u_rd_water_level, u_ae_thresh;

    int vectors_applied = 0;
    int miscompares     = 0;

    logic [31:0] qm[$];
    logic [31:0] ql[$];
    logic [31:0] qu[$];
    logic [31:0] exp_m, exp_l, exp_u;
    logic [31:0] word;

    sync_width_conv_fifo #(
        .WR_DATA_WIDTH(32), .RD_DATA_WIDTH(8), .DEPTH_WIDTH(12), .MSB_FIRST(1'b1), .OUTPUT_REG(1'b0)
    ) u_dut (
        .clk(clk), .rst_n(tb_rst),
        .wr_data(m_wr_data), .wr_en(m_wr_en), .wr_full(m_wr_full), .almost_full(m_almost_full),
        .wr_water_level(m_wr_water_level), .af_thresh(m_af_thresh), .wr_overflow(m_wr_overflow),
        .rd_data(m_rd_data), .rd_en(m_rd_en), .rd_valid(m_rd_valid), .rd_empty(m_rd_empty),
        .almost_empty(m_almost_empty), .rd_water_level(m_rd_water_level), .ae_thresh(m_ae_thresh),
        .rd_underflow(m_rd_underflow)
    );

    sync_width_conv_fifo #(
        .WR_DATA_WIDTH(32), .RD_DATA_WIDTH(8), .DEPTH_WIDTH(4), .MSB_FIRST(1'b0), .OUTPUT_REG(1'b0)
    ) u_lsb (
        .clk(clk), .rst_n(tb_rst),
        .wr_data(l_wr_data), .wr_en(l_wr_en), .wr_full(l_wr_full), .almost_full(l_almost_full),
        .wr_water_level(l_wr_water_level), .af_thresh(l_af_thresh), .wr_overflow(l_wr_overflow),
        .rd_data(l_rd_data), .rd_en(l_rd_en), .rd_valid(l_rd_valid), .rd_empty(l_rd_empty),
        .almost_empty(l_almost_empty), .rd_water_level(l_rd_water_level), .ae_thresh(l_ae_thresh),
        .rd_underflow(l_rd_underflow)
    );

    sync_width_conv_fifo #(
        .WR_DATA_WIDTH(8), .RD_DATA_WIDTH(32), .DEPTH_WIDTH(6), .MSB_FIRST(1'b1), .OUTPUT_REG(1'b1)
    ) u_up (
        .clk(clk), .rst_n(tb_rst),
        .wr_data(u_wr_data), .wr_en(u_wr_en), .wr_full(u_wr_full), .almost_full(u_almost_full),
        .wr_water_level(u_wr_water_level), .af_thresh(u_af_thresh), .wr_overflow(u_wr_overflow),
        .rd_data(u_rd_data), .rd_en(u_rd_en), .rd_valid(u_rd_valid), .rd_empty(u_rd_empty),
        .almost_empty(u_almost_empty), .rd_water_level(u_rd_water_level), .ae_thresh(u_ae_thresh),
        .rd_underflow(u_rd_underflow)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors_applied++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive one cycle on instance sel (0 main, 1 lsb, 2 up); outputs are
    // valid on return (1 ns after the edge).
    task automatic applyStimulus(input int sel, input logic wr, input logic [31:0] data, input logic rd);
        case (sel)
            0: begin m_wr_en = wr; m_wr_data = data; m_rd_en = rd; end
            1: begin l_wr_en = wr; l_wr_data = data; l_rd_en = rd; end
            default: begin u_wr_en = wr; u_wr_data = data[7:0]; u_rd_en = rd; end
        endcase
        @(posedge clk);
        #1;
        m_wr_en = 1'b0; m_rd_en = 1'b0;
        l_wr_en = 1'b0; l_rd_en = 1'b0;
        u_wr_en = 1'b0; u_rd_en = 1'b0;
    endtask

    task automatic pushMain(input logic [31:0] w);
        qm.push_back({24'h0, w[31:24]});
        qm.push_back({24'h0, w[23:16]});
        qm.push_back({24'h0, w[15:8]});
        qm.push_back({24'h0, w[7:0]});
    endtask

    task automatic pushLsb(input logic [31:0] w);
        ql.push_back({24'h0, w[7:0]});
        ql.push_back({24'h0, w[15:8]});
        ql.push_back({24'h0, w[23:16]});
        ql.push_back({24'h0, w[31:24]});
    endtask

    // Scoreboard monitors: one per instance, sampled on the falling edge.
    always @(negedge clk) begin
        if (m_rd_valid === 1'b1) begin
            if (qm.size() == 0) begin
                vectors_applied++;
                miscompares++;
                $display("[TB] FAIL main_unexpected: rd_valid with rd_data 0x%0h, nothing expected", m_rd_data);
            end else begin
                exp_m = qm.pop_front();
                checkOutput("main_rd_data", {24'h0, m_rd_data}, exp_m);
            end
        end
    end

    always @(negedge clk) begin
        if (l_rd_valid === 1'b1) begin
            if (ql.size() == 0) begin
                vectors_applied++;
                miscompares++;
                $display("[TB] FAIL lsb_unexpected: rd_valid with rd_data 0x%0h, nothing expected", l_rd_data);
            end else begin
                exp_l = ql.pop_front();
                checkOutput("lsb_rd_data", {24'h0, l_rd_data}, exp_l);
            end
        end
    end

    always @(negedge clk) begin
        if (u_rd_valid === 1'b1) begin
            if (qu.size() == 0) begin
                vectors_applied++;
                miscompares++;
                $display("[TB] FAIL up_unexpected: rd_valid with rd_data 0x%0h, nothing expected", u_rd_data);
            end else begin
                exp_u = qu.pop_front();
                checkOutput("up_rd_data", u_rd_data, exp_u);
            end
        end
    end

    initial begin
        m_wr_en = 0; m_rd_en = 0; m_wr_data = '0; m_af_thresh = 13'd128; m_ae_thresh = 13'd5;
        l_wr_en = 0; l_rd_en = 0; l_wr_data = '0; l_af_thresh = 5'd3;    l_ae_thresh = 5'd0;
        u_wr_en = 0; u_rd_en = 0; u_wr_data = '0; u_af_thresh = 7'd60;   u_ae_thresh = 7'd0;
        tb_rst = 1'b1;
        #2 tb_rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset values
        checkOutput("rst_rd_data",      {24'h0, m_rd_data}, 0);
        checkOutput("rst_rd_valid",     m_rd_valid, 0);
        checkOutput("rst_wr_full",      m_wr_full, 0);
        checkOutput("rst_rd_empty",     m_rd_empty, 1);
        checkOutput("rst_almost_full",  m_almost_full, 0);
        checkOutput("rst_almost_empty", m_almost_empty, 1);
        checkOutput("rst_wr_level",     m_wr_water_level, 0);
        checkOutput("rst_rd_level",     m_rd_water_level, 0);
        checkOutput("rst_overflow",     m_wr_overflow, 0);
        checkOutput("rst_underflow",    m_rd_underflow, 0);
        tb_rst = 1'b1;
        applyStimulus(0, 1'b0, 32'h0, 1'b0);

        // Basic 32->8 MSB-first unpack
        pushMain(32'hAABBCCDD);
        applyStimulus(0, 1'b1, 32'hAABBCCDD, 1'b0);
        checkOutput("basic_rd_empty", m_rd_empty, 0);
        checkOutput("basic_rd_level", m_rd_water_level, 4);
        checkOutput("basic_wr_level", m_wr_water_level, 1);
        applyStimulus(0, 1'b0, 32'h0, 1'b1);
        checkOutput("basic_latency_0", m_rd_valid, 0);
        applyStimulus(0, 1'b0, 32'h0, 1'b1);
        checkOutput("basic_latency_1", m_rd_valid, 1);
        checkOutput("basic_first_byte", {24'h0, m_rd_data}, 32'hAA);
        applyStimulus(0, 1'b0, 32'h0, 1'b1);
        applyStimulus(0, 1'b0, 32'h0, 1'b1);
        checkOutput("basic_empty_after", m_rd_empty, 1);
        repeat (2) applyStimulus(0, 1'b0, 32'h0, 1'b0);
        checkOutput("basic_hold_data", {24'h0, m_rd_data}, 32'hDD);
        checkOutput("basic_hold_valid", m_rd_valid, 0);

        // Fill with a decrementing counter, with threshold and full checks
        for (int k = 0; k < 1024; k++) begin
            word = 32'hFFFF_FFFF - 32'(k);
            pushMain(word);
            applyStimulus(0, 1'b1, word, 1'b0);
            if (k == 0)    checkOutput("fill_ae_one_word", m_almost_empty, 1);
            if (k == 1)    checkOutput("fill_ae_two_words", m_almost_empty, 0);
            if (k == 126)  checkOutput("fill_af_127", m_almost_full, 0);
            if (k == 127)  checkOutput("fill_af_128", m_almost_full, 1);
            if (k == 1022) checkOutput("fill_full_1023", m_wr_full, 0);
        end
        checkOutput("fill_wr_full", m_wr_full, 1);
        checkOutput("fill_wr_level", m_wr_water_level, 1024);
        checkOutput("fill_rd_level", m_rd_water_level, 4096);
        applyStimulus(0, 1'b1, 32'h12345678, 1'b0);
        checkOutput("overflow_pulse", m_wr_overflow, 1);
        checkOutput("overflow_level", m_wr_water_level, 1024);
        applyStimulus(0, 1'b0, 32'h0, 1'b0);
        checkOutput("overflow_clear", m_wr_overflow, 0);

        // Drain every byte back-to-back, then one read too many
        for (int k = 0; k < 4096; k++) begin
            applyStimulus(0, 1'b0, 32'h0, 1'b1);
            if (k == 4094) checkOutput("drain_one_left", m_rd_water_level, 1);
        end
        checkOutput("drain_rd_empty", m_rd_empty, 1);
        checkOutput("drain_rd_level", m_rd_water_level, 0);
        checkOutput("drain_almost_empty", m_almost_empty, 1);
        checkOutput("drain_wr_full", m_wr_full, 0);
        repeat (2) applyStimulus(0, 1'b0, 32'h0, 1'b0);
        applyStimulus(0, 1'b0, 32'h0, 1'b1);
        checkOutput("underflow_pulse", m_rd_underflow, 1);
        checkOutput("underflow_no_valid", m_rd_valid, 0);
        applyStimulus(0, 1'b0, 32'h0, 1'b0);
        checkOutput("underflow_clear", m_rd_underflow, 0);
        checkOutput("underflow_hold_data", {24'h0, m_rd_data}, 32'h00);

        // LSB-first order on the small instance, then two fill/drain rounds that wrap pointers
        pushLsb(32'hAABBCCDD);
        applyStimulus(1, 1'b1, 32'hAABBCCDD, 1'b0);
        checkOutput("lsb_rd_level", l_rd_water_level, 4);
        repeat (4) applyStimulus(1, 1'b0, 32'h0, 1'b1);
        repeat (2) applyStimulus(1, 1'b0, 32'h0, 1'b0);
        checkOutput("lsb_last_byte", {24'h0, l_rd_data}, 32'hAA);
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) begin
                word = 32'h3C5A_0F10 + 32'(r * 16 + k);
                pushLsb(word);
                applyStimulus(1, 1'b1, word, 1'b0);
                if (k == 1) checkOutput("lsb_af_2", l_almost_full, 0);
                if (k == 2) checkOutput("lsb_af_3", l_almost_full, 1);
                if (k == 2) checkOutput("lsb_full_3", l_wr_full, 0);
            end
            checkOutput("lsb_full_4", l_wr_full, 1);
            repeat (16) applyStimulus(1, 1'b0, 32'h0, 1'b1);
            checkOutput("lsb_drained", l_rd_empty, 1);
            checkOutput("lsb_not_full", l_wr_full, 0);
            repeat (2) applyStimulus(1, 1'b0, 32'h0, 1'b0);
        end

        // Upsize 8->32: partial words keep rd_empty set; two-stage read latency
        applyStimulus(2, 1'b1, 32'h11, 1'b0);
        checkOutput("up_empty_1", u_rd_empty, 1);
        applyStimulus(2, 1'b1, 32'h22, 1'b0);
        applyStimulus(2, 1'b1, 32'h33, 1'b0);
        checkOutput("up_empty_3", u_rd_empty, 1);
        checkOutput("up_wr_level_3", u_wr_water_level, 3);
        checkOutput("up_rd_level_3", u_rd_water_level, 0);
        applyStimulus(2, 1'b0, 32'h0, 1'b1);
        checkOutput("up_partial_underflow", u_rd_underflow, 1);
        qu.push_back(32'h11223344);
        applyStimulus(2, 1'b1, 32'h44, 1'b0);
        checkOutput("up_empty_4", u_rd_empty, 0);
        checkOutput("up_rd_level_4", u_rd_water_level, 1);
        checkOutput("up_wr_level_4", u_wr_water_level, 4);
        applyStimulus(2, 1'b0, 32'h0, 1'b1);
        checkOutput("up_latency_0", u_rd_valid, 0);
        checkOutput("up_empty_after", u_rd_empty, 1);
        applyStimulus(2, 1'b0, 32'h0, 1'b0);
        checkOutput("up_latency_1", u_rd_valid, 0);
        applyStimulus(2, 1'b0, 32'h0, 1'b0);
        checkOutput("up_latency_2", u_rd_valid, 1);
        checkOutput("up_word", u_rd_data, 32'h11223344);
        applyStimulus(2, 1'b0, 32'h0, 1'b0);

        // Concurrent traffic on main: one write per four reads keeps 8 units stored
        pushMain(32'h0102_0304);
        applyStimulus(0, 1'b1, 32'h0102_0304, 1'b0);
        pushMain(32'h0506_0708);
        applyStimulus(0, 1'b1, 32'h0506_0708, 1'b0);
        for (int it = 0; it < 20; it++) begin
            word = 32'hC0DE_0000 + 32'(it * 32'h0101);
            pushMain(word);
            applyStimulus(0, 1'b1, word, 1'b1);
            checkOutput("conc_rd_empty", m_rd_empty, 0);
            checkOutput("conc_almost_empty", m_almost_empty, 0);
            for (int j = 0; j < 3; j++) begin
                applyStimulus(0, 1'b0, 32'h0, 1'b1);
                checkOutput("conc_rd_empty", m_rd_empty, 0);
                checkOutput("conc_almost_empty", m_almost_empty, 0);
            end
            checkOutput("conc_rd_level", m_rd_water_level, 8);
            checkOutput("conc_wr_level", m_wr_water_level, 2);
        end

        // Asynchronous reset in the middle of traffic (tb_rst is active low)
        m_wr_en = 1'b1; m_rd_en = 1'b1; m_wr_data = 32'hDEAD_BEEF;
        @(posedge clk);
        #3;
        tb_rst = 1'b0;
        m_wr_en = 1'b0; m_rd_en = 1'b0;
        qm.delete(); ql.delete(); qu.delete();
        #1;
        checkOutput("mid_rst_rd_data",      {24'h0, m_rd_data}, 0);
        checkOutput("mid_rst_rd_valid",     m_rd_valid, 0);
        checkOutput("mid_rst_wr_full",      m_wr_full, 0);
        checkOutput("mid_rst_rd_empty",     m_rd_empty, 1);
        checkOutput("mid_rst_almost_full",  m_almost_full, 0);
        checkOutput("mid_rst_almost_empty", m_almost_empty, 1);
        checkOutput("mid_rst_wr_level",     m_wr_water_level, 0);
        checkOutput("mid_rst_rd_level",     m_rd_water_level, 0);
        checkOutput("mid_rst_overflow",     m_wr_overflow, 0);
        checkOutput("mid_rst_underflow",    m_rd_underflow, 0);
        @(posedge clk);
        #1;
        tb_rst = 1'b1;
        applyStimulus(0, 1'b0, 32'h0, 1'b0);

        // Fresh sequence after reset release
        pushMain(32'h0A1B_2C3D);
        applyStimulus(0, 1'b1, 32'h0A1B_2C3D, 1'b0);
        checkOutput("post_rst_wr_level", m_wr_water_level, 1);
        repeat (4) applyStimulus(0, 1'b0, 32'h0, 1'b1);
        checkOutput("post_rst_empty", m_rd_empty, 1);
        repeat (3) applyStimulus(0, 1'b0, 32'h0, 1'b0);
        checkOutput("post_rst_last_byte", {24'h0, m_rd_data}, 32'h3D);

        // Every expected word must have been observed
        checkOutput("sb_main_left", qm.size(), 0);
        checkOutput("sb_lsb_left", ql.size(), 0);
        checkOutput("sb_up_left", qu.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
